// File: rtl/dp_sync_ram_if.sv
// rtl/dp_sync_ram_if.sv - port bundle for dp_sync_ram: write port A, read port B
interface dp_sync_ram_if #(
  parameter int WIDTH   = 32,
  parameter int WIDTHAD = 8
);
  logic               clocken0;
  logic               wren_a;
  logic [WIDTHAD-1:0] address_a;
  logic [WIDTH-1:0]   data_a;
  logic [WIDTHAD-1:0] address_b;
  logic               addressstall_b;
  logic [WIDTH-1:0]   q_b;

  modport master (
    output clocken0, wren_a, address_a, data_a, address_b, addressstall_b,
    input  q_b
  );

  modport slave (
    input  clocken0, wren_a, address_a, data_a, address_b, addressstall_b,
    output q_b
  );
endinterface

// File: rtl/dp_sync_ram.sv
// rtl/dp_sync_ram.sv - single-clock simple dual-port RAM, old-data read-during-write
// Optional output register stage selected by DP_SYNC_RAM_OUTREG_EN (2-cycle read latency).
module dp_sync_ram #(
  parameter int WIDTH    = 32,
  parameter int WIDTHAD  = 8,
  parameter int NUMWORDS = 256
) (
  input  logic          clock0,
  input  logic          sclr,
  dp_sync_ram_if.slave  bus
);
  localparam int IW = (NUMWORDS > 1) ? $clog2(NUMWORDS) : 1;
  localparam logic [WIDTHAD:0] DEPTH = (WIDTHAD + 1)'(NUMWORDS);

  logic [WIDTH-1:0]   mem [NUMWORDS] = '{default: '0};
  logic [WIDTHAD-1:0] addr_b_reg = '0;
  logic [WIDTH-1:0]   rd_latch = '0;

  logic          wr_in_range;
  logic          rd_in_range;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign wr_in_range = {1'b0, bus.address_a} < DEPTH;
  assign rd_in_range = {1'b0, bus.address_b} < DEPTH;
  assign wr_idx      = bus.address_a[IW-1:0];
  assign rd_idx      = bus.address_b[IW-1:0];

  // Array contents survive sclr; out-of-range writes fall on the floor.
  always_ff @(posedge clock0) begin
    if (bus.clocken0 && bus.wren_a && wr_in_range) begin
      mem[wr_idx] <= bus.data_a;
    end
  end

  // Sampling mem here sees pre-edge contents, giving old data on a same-edge collision.
  always_ff @(posedge clock0) begin
    if (sclr) begin
      addr_b_reg <= '0;
      rd_latch   <= '0;
    end else if (!bus.addressstall_b) begin
      addr_b_reg <= bus.address_b;
      rd_latch   <= rd_in_range ? mem[rd_idx] : '0;
    end
  end

  // Latch and registered address load together, so an out-of-range address always pairs with zero data.
  assert property (@(posedge clock0)
    !({1'b0, addr_b_reg} < DEPTH) |-> (rd_latch == '0));

`ifdef DP_SYNC_RAM_OUTREG_EN
  logic [WIDTH-1:0] q_reg = '0;

  always_ff @(posedge clock0) begin
    if (sclr) begin
      q_reg <= '0;
    end else begin
      q_reg <= rd_latch;
    end
  end

  assign bus.q_b = q_reg;
`else
  assign bus.q_b = rd_latch;
`endif
endmodule

// File: tb/tb_dp_sync_ram.sv
// tb/tb_dp_sync_ram.sv - directed and randomized check of dp_sync_ram against an array model
module tb_dp_sync_ram;
  localparam int W  = 32;
  localparam int AW = 8;
  localparam int N  = 200;

  logic clock0 = 1'b0;
  logic sclr   = 1'b1;

  always #5 clock0 = ~clock0;

  dp_sync_ram_if #(.WIDTH(W), .WIDTHAD(AW)) bus ();

  dp_sync_ram #(.WIDTH(W), .WIDTHAD(AW), .NUMWORDS(N)) dut (
    .clock0 (clock0),
    .sclr   (sclr),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] ref_mem [2**AW];
  logic [W-1:0] exp_latch;
  logic [W-1:0] exp_qreg;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] expected_q();
`ifdef DP_SYNC_RAM_OUTREG_EN
    return exp_qreg;
`else
    return exp_latch;
`endif
  endfunction

  task automatic step(input logic s, input logic ce, input logic we,
                      input logic [AW-1:0] aa, input logic [W-1:0] da,
                      input logic [AW-1:0] ab, input logic st, input string tag);
    logic [W-1:0] rd;
    sclr               = s;
    bus.clocken0       = ce;
    bus.wren_a         = we;
    bus.address_a      = aa;
    bus.data_a         = da;
    bus.address_b      = ab;
    bus.addressstall_b = st;
    @(posedge clock0);
    rd       = (int'(ab) < N) ? ref_mem[ab] : '0;
    exp_qreg = s ? '0 : exp_latch;
    if (s) exp_latch = '0;
    else if (!st) exp_latch = rd;
    if (ce && we && int'(aa) < N) ref_mem[aa] = da;
    #1 check(tag, bus.q_b, expected_q());
  endtask

  task automatic wr(input logic [AW-1:0] aa, input logic [W-1:0] da);
    step(1'b0, 1'b1, 1'b1, aa, da, '0, 1'b1, "wr");
  endtask

  task automatic rd(input logic [AW-1:0] ab, input string tag);
    step(1'b0, 1'b0, 1'b0, '0, '0, ab, 1'b0, tag);
  endtask

  task automatic hold(input string tag);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, tag);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    case ($urandom_range(0, 3))
      0, 1:    a = AW'($urandom_range(0, 7));
      2:       a = AW'($urandom_range(N - 6, N + 5));
      default: a = AW'($urandom);
    endcase
    return a;
  endfunction

  initial begin
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
    exp_latch          = '0;
    exp_qreg           = '0;
    bus.clocken0       = 1'b0;
    bus.wren_a         = 1'b0;
    bus.address_a      = '0;
    bus.data_a         = '0;
    bus.address_b      = '0;
    bus.addressstall_b = 1'b0;
    #1 check("power_up", bus.q_b, '0);

    step(1'b1, 1'b0, 1'b0, '0, '0, 8'h05, 1'b0, "rst0");
    step(1'b1, 1'b0, 1'b0, '0, '0, 8'h05, 1'b0, "rst1");
    rd(8'h05, "init_rd");
    hold("init_hold");
    check("init_zero", bus.q_b, 32'h0);

    wr(8'h10, 32'hDEADBEEF);
    rd(8'h10, "wr_rd");
    hold("wr_rd_hold");
    check("wr_rd_val", bus.q_b, 32'hDEADBEEF);

    wr(8'h20, 32'h11111111);
    step(1'b0, 1'b1, 1'b1, 8'h20, 32'h22222222, 8'h20, 1'b0, "coll");
    hold("coll_hold");
    check("coll_old", bus.q_b, 32'h11111111);
    rd(8'h20, "coll_rerd");
    hold("coll_rerd_hold");
    check("coll_new", bus.q_b, 32'h22222222);

    wr(8'h30, 32'hAAAA0000);
    rd(8'h30, "stall_rd");
    hold("stall_rd_hold");
    check("stall_first", bus.q_b, 32'hAAAA0000);
    step(1'b0, 1'b1, 1'b1, 8'h30, 32'hBBBB0000, 8'h31, 1'b1, "stall_wr");
    step(1'b0, 1'b0, 1'b0, '0, '0, 8'h55, 1'b1, "stall_tog");
    check("stall_hold", bus.q_b, 32'hAAAA0000);
    rd(8'h30, "stall_rel");
    hold("stall_rel_hold");
    check("stall_release", bus.q_b, 32'hBBBB0000);

    step(1'b0, 1'b0, 1'b1, 8'h40, 32'h12345678, '0, 1'b1, "gate_wr");
    rd(8'h40, "gate_rd");
    hold("gate_hold");
    check("gate_val", bus.q_b, 32'h0);

    wr(8'(N - 1), 32'h0BADCAFE);
    wr(8'(N), 32'hFFFF0001);
    rd(8'(N - 1), "last_rd");
    hold("last_hold");
    check("last_word", bus.q_b, 32'h0BADCAFE);
    rd(8'(N), "oor_rd");
    hold("oor_hold");
    check("oor_zero", bus.q_b, 32'h0);

    wr(8'h50, 32'hCAFEF00D);
    rd(8'h50, "mid_rd");
    hold("mid_hold");
    check("mid_before", bus.q_b, 32'hCAFEF00D);
    step(1'b1, 1'b0, 1'b0, '0, '0, 8'h50, 1'b0, "mid_rst");
    check("mid_rst_zero", bus.q_b, 32'h0);
    rd(8'h50, "mid_rerd");
    hold("mid_rerd_hold");
    check("mid_after", bus.q_b, 32'hCAFEF00D);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           rand_addr(), W'($urandom), rand_addr(), ($urandom_range(0, 3) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
